dhazard_ctrl: RTL and testbench

- Producer side of the decode-stage forwarding interface.
- Keeps a shadow scoreboard of in-flight destination registers in the E, M and W stages.
- Drives the per-operand forward_t selects consumed by the decode forwarding muxes, plus the stall/bubble controls for load-use, execute-stage and multi-cycle hazards.
- Sits beside the decode stage; advances in lockstep with the main pipeline registers.

---
 rtl/dhazard_ctrl_if.sv | 32 +++
 rtl/dhazard_ctrl.sv | 118 +++++++++++
 tb/tb_dhazard_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dhazard_ctrl_if.sv
// Decode-stage forwarding/hazard bus: decode instruction fields in, forward selects and stall controls out.
// CNT_W sizes the optional stalled-cycle counter.
interface dhazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             d_valid;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic             d_use1;
    logic             d_use2;
    logic [4:0]       d_rd;
    logic             d_regwrite;
    logic [1:0]       d_wbsel;
    logic             d_mc;
    logic             flush;
    logic [1:0]       fwd1;
    logic [1:0]       fwd2;
    logic             stall_fd;
    logic             bubble_e;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_valid, d_rs1, d_rs2, d_use1, d_use2, d_rd, d_regwrite, d_wbsel, d_mc, flush,
        input  fwd1, fwd2, stall_fd, bubble_e, mc_busy, stall_cnt
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_use1, d_use2, d_rd, d_regwrite, d_wbsel, d_mc, flush,
        output fwd1, fwd2, stall_fd, bubble_e, mc_busy, stall_cnt
    );
endinterface

// File: rtl/dhazard_ctrl.sv
// Decode-side hazard unit: E/M/W shadow scoreboard driving forward selects, stall_fd and bubble_e.
// Selects and stalls are combinational from scoreboard + decode; scoreboard advances every clk.
// Multi-cycle ops hold E for MC_LAT cycles; HAZARD_PERF_EN adds a saturating stalled-cycle counter.
module dhazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    dhazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        FWD_RD     = 2'd0,
        FWD_RESULT = 2'd1,
        FWD_PC4    = 2'd2,
        FWD_WD     = 2'd3
    } forward_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic [1:0] wbsel;
        logic       mc;
    } sb_entry_t;

    localparam int              MC_W    = $clog2(MC_LAT);
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LAT - 1);

    sb_entry_t       e_q, e_d, m_q, m_d, w_q, w_d;
    logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
    sb_entry_t       dec_entry;
    logic            mc_busy, e_hit, lu_hit, hazard, stall_fd, bubble_e;
    forward_t        fwd1, fwd2;
    logic            unused_w;

    function automatic logic hit(input sb_entry_t ent, input logic [4:0] rs, input logic use_b);
        return ent.valid && ent.regwrite && (ent.rd == rs) && (rs != 5'd0) && use_b;
    endfunction

    // M forwards only ALU or PC+4 results; a load in M falls through to the W check.
    function automatic forward_t fwd_sel(input sb_entry_t m, input sb_entry_t w,
                                         input logic [4:0] rs, input logic use_b);
        if (hit(m, rs, use_b) && m.wbsel == 2'd0) return FWD_RESULT;
        if (hit(m, rs, use_b) && m.wbsel == 2'd1) return FWD_PC4;
        if (hit(w, rs, use_b))                     return FWD_WD;
        return FWD_RD;
    endfunction

    always_comb begin
        mc_busy   = (mc_cnt_q != '0);
        fwd1      = fwd_sel(m_q, w_q, hz.d_rs1, hz.d_use1);
        fwd2      = fwd_sel(m_q, w_q, hz.d_rs2, hz.d_use2);
        e_hit     = hit(e_q, hz.d_rs1, hz.d_use1) || hit(e_q, hz.d_rs2, hz.d_use2);
        lu_hit    = (hit(m_q, hz.d_rs1, hz.d_use1) || hit(m_q, hz.d_rs2, hz.d_use2))
                    && (m_q.wbsel == 2'd2);
        hazard    = (hz.d_valid && (e_hit || lu_hit)) || mc_busy;
        stall_fd  = hazard && !hz.flush;
        bubble_e  = hazard && !mc_busy && !hz.flush;
        dec_entry = '{valid: 1'b1, rd: hz.d_rd, regwrite: hz.d_regwrite,
                      wbsel: hz.d_wbsel, mc: hz.d_mc};

        w_d = m_q;
        if (mc_busy) begin
            // E is held by the multi-cycle op, so M drains rather than receiving a copy.
            m_d = '0;
            e_d = e_q;
        end else begin
            m_d = e_q;
            e_d = (hz.d_valid && !bubble_e) ? dec_entry : '0;
        end
        if (hz.flush) e_d = '0;

        if (hz.flush)                 mc_cnt_d = '0;
        else if (mc_busy)             mc_cnt_d = mc_cnt_q - 1'b1;
        else if (e_d.valid && e_d.mc) mc_cnt_d = MC_LOAD;
        else                          mc_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            mc_cnt_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_q      <= w_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign unused_w    = ^{w_q.wbsel, w_q.mc};
    assign hz.fwd1     = fwd1;
    assign hz.fwd2     = fwd2;
    assign hz.stall_fd = stall_fd;
    assign hz.bubble_e = bubble_e;
    assign hz.mc_busy  = mc_busy;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_fd && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_dhazard_ctrl.sv
// Directed bench for dhazard_ctrl: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_dhazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dhazard_ctrl_if #(.CNT_W(32)) hz ();
    dhazard_ctrl #(.MC_LAT(4), .CNT_W(32)) dut (.clk(clk), .reset(reset), .hz(hz));

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] wb;
        logic       mc;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       fl;
        logic [1:0] f1;
        logic [1:0] f2;
        logic       st;
        logic       bu;
        logic       busy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int row_id = 0;
    int exp_cnt = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic vld, input logic [4:0] rd,
                                input logic rw, input logic [1:0] wb, input logic mc,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic fl,
                                input logic [1:0] f1, input logic [1:0] f2,
                                input logic st, input logic bu, input logic busy);
        vec_t v;
        v = '{rst: rst, vld: vld, rd: rd, rw: rw, wb: wb, mc: mc, rs1: rs1, u1: u1,
              rs2: rs2, u2: u2, fl: fl, f1: f1, f2: f2, st: st, bu: bu, busy: busy};
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row_id, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        int exp_sc;
        @(posedge clk);
        #1;
        reset         = v.rst;
        hz.d_valid    = v.vld;
        hz.d_rd       = v.rd;
        hz.d_regwrite = v.rw;
        hz.d_wbsel    = v.wb;
        hz.d_mc       = v.mc;
        hz.d_rs1      = v.rs1;
        hz.d_use1     = v.u1;
        hz.d_rs2      = v.rs2;
        hz.d_use2     = v.u2;
        hz.flush      = v.fl;
        @(negedge clk);
`ifdef HAZARD_PERF_EN
        exp_sc = exp_cnt;
`else
        exp_sc = 0;
`endif
        if (!v.rst) begin
            cmp("fwd1", 32'(hz.fwd1), 32'(v.f1));
            cmp("fwd2", 32'(hz.fwd2), 32'(v.f2));
            cmp("stall_fd", 32'(hz.stall_fd), 32'(v.st));
            cmp("bubble_e", 32'(hz.bubble_e), 32'(v.bu));
            cmp("mc_busy", 32'(hz.mc_busy), 32'(v.busy));
            cmp("stall_cnt", hz.stall_cnt, 32'(exp_sc));
        end
        if (v.rst) exp_cnt = 0;
        else if (v.st) exp_cnt++;
        row_id++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r, mul8;
        hz.d_valid = 0; hz.d_rd = 0; hz.d_regwrite = 0; hz.d_wbsel = 0; hz.d_mc = 0;
        hz.d_rs1 = 0; hz.d_use1 = 0; hz.d_rs2 = 0; hz.d_use2 = 0; hz.flush = 0;
        r    = mk(1,0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0);
        mul8 = mk(0,1, 8,1,0,1, 0,0,0,0, 0, 0,0,0,0,0);

        // reset state
        tbl.push_back(r);
        tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        // ALU x5, consumer reads x5 on both operands
        tbl.push_back(mk(0,1, 5,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1, 6,1,0,0, 5,1,5,1, 0, 0,0,1,1,0));
        tbl.push_back(mk(0,1, 6,1,0,0, 5,1,5,1, 0, 1,1,0,0,0));
        // load x7, dependent on rs2: two stalls then Wd
        tbl.push_back(r);
        tbl.push_back(mk(0,1, 7,1,2,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1, 9,1,0,0, 0,0,7,1, 0, 0,0,1,1,0));
        tbl.push_back(mk(0,1, 9,1,0,0, 0,0,7,1, 0, 0,0,1,1,0));
        tbl.push_back(mk(0,1, 9,1,0,0, 0,0,7,1, 0, 0,3,0,0,0));
        // jal x1, three unrelated, read x1: retired, RD
        tbl.push_back(r);
        tbl.push_back(mk(0,1, 1,1,1,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,10,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,11,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,12,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,13,1,0,0, 1,1,0,0, 0, 0,0,0,0,0));
        // jal x1 then immediate read: one stall then PCplus4
        tbl.push_back(r);
        tbl.push_back(mk(0,1, 1,1,1,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,13,1,0,0, 1,1,0,0, 0, 0,0,1,1,0));
        tbl.push_back(mk(0,1,13,1,0,0, 1,1,0,0, 0, 2,0,0,0,0));
        // x0 is never a hazard nor forwarded
        tbl.push_back(r);
        tbl.push_back(mk(0,1, 0,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1, 3,1,0,0, 0,1,0,1, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1, 4,1,0,0, 0,1,0,1, 0, 0,0,0,0,0));
        // W match plus E hazard on x6 still stalls
        tbl.push_back(r);
        tbl.push_back(mk(0,1, 6,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,10,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1, 6,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,14,1,0,0, 6,1,0,0, 0, 3,0,1,1,0));
        tbl.push_back(mk(0,1,14,1,0,0, 6,1,0,0, 0, 1,0,0,0,0));
        // add x9, mul x8 (MC_LAT 4): x9 drains M->W->gone while E held
        tbl.push_back(r);
        tbl.push_back(mk(0,1, 9,1,0,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mul8);
        tbl.push_back(mk(0,1,15,1,0,0, 8,1,9,1, 0, 0,1,1,0,1));
        tbl.push_back(mk(0,1,15,1,0,0, 8,1,9,1, 0, 0,3,1,0,1));
        tbl.push_back(mk(0,1,15,1,0,0, 8,1,9,1, 0, 0,0,1,0,1));
        tbl.push_back(mk(0,1,15,1,0,0, 8,1,9,1, 0, 0,0,1,1,0));
        tbl.push_back(mk(0,1,15,1,0,0, 8,1,9,1, 0, 1,0,0,0,0));
        // flush during load-use: consumer x12 must not reach E
        tbl.push_back(r);
        tbl.push_back(mk(0,1, 7,1,2,0, 0,0,0,0, 0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,12,1,0,0, 7,1,0,0, 0, 0,0,1,1,0));
        tbl.push_back(mk(0,1,12,1,0,0, 7,1,0,0, 1, 0,0,0,0,0));
        tbl.push_back(mk(0,1,13,1,0,0,12,1,0,0, 0, 0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // flush while the multi-cycle op is running clears the counter
        step(r);
        step(mul8);
        step(mk(0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,1,0,1));
        step(mk(0,0, 0,0,0,0, 0,0,0,0, 1, 0,0,0,0,1));
        step(mk(0,1,15,1,0,0, 8,1,0,0, 0, 0,0,0,0,0));
        step(mk(0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0));

        // reset mid multi-cycle leaves nothing pending
        step(mul8);
        step(mk(0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,1,0,1));
        step(r);
        step(mk(0,1,15,1,0,0, 8,1,8,1, 0, 0,0,0,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
